// File: rtl/imdct_pkg.sv
// Shared types and constants for the IMDCT job sequencer.
package imdct_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE_GO,
      PRE_WAIT,
      FFT_GO,
      FFT_WAIT,
      POST_GO,
      POST_WAIT,
      FIN
   } seq_state_t;

   localparam logic MODE_PRE  = 1'b0;
   localparam logic MODE_POST = 1'b1;

   localparam logic RAM_IMDCT = 1'b0;
   localparam logic RAM_FFT   = 1'b1;

   // States that launch an engine pass
   function automatic logic is_go(input seq_state_t s);
      return (s == PRE_GO) || (s == FFT_GO) || (s == POST_GO);
   endfunction

   // States that wait on an engine done pulse
   function automatic logic is_wait(input seq_state_t s);
      return (s == PRE_WAIT) || (s == FFT_WAIT) || (s == POST_WAIT);
   endfunction

endpackage

// File: rtl/imdct_wdog.sv
// Per-phase watchdog: saturating counter, expired once it holds all-ones.
module imdct_wdog #(
   parameter int unsigned TO_W = 12
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [TO_W-1:0] CNT_MAX  = '1;
   localparam logic [TO_W-1:0] CNT_LAST = CNT_MAX - TO_W'(1);

   logic [TO_W-1:0] cnt;

   // Count wait cycles; expired tracks cnt == all-ones as a register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         expired <= 1'b0;
      end else if (clr) begin
         cnt     <= '0;
         expired <= 1'b0;
      end else if (en && (cnt != CNT_MAX)) begin
         cnt     <= cnt + TO_W'(1);
         expired <= (cnt == CNT_LAST);
      end
   end

endmodule

// File: rtl/imdct_seq.sv
// IMDCT job sequencer: pre-twiddle, FFT handoff, post-twiddle, with watchdog.
module imdct_seq #(
   parameter int unsigned TO_W = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       job_valid,
   output logic       job_ready,
   input  logic       job_tabidx,
   input  logic [4:0] job_es,
   output logic       imdct_start,
   output logic       imdct_mode,
   output logic       imdct_tabidx,
   output logic [4:0] imdct_es,
   input  logic       imdct_done,
   output logic       fft_start,
   input  logic       fft_done,
   output logic       ram_sel,
   output logic       busy,
   output logic       job_done,
   output logic       err,
   input  logic       err_clr
);

   import imdct_pkg::*;

   seq_state_t state, state_n;
   logic       timeout_c, accept_c, wd_clr_c, wd_en_c, wd_expired;
   logic       ready_n, busy_n, istart_n, fstart_n, ram_n, jdone_n, mode_n, err_n;

   // Watchdog restarts in each GO state and runs through the following wait
   assign wd_clr_c = is_go(state);
   assign wd_en_c  = is_wait(state);

   imdct_wdog #(.TO_W(TO_W)) u_wdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wd_clr_c),
      .en      (wd_en_c),
      .expired (wd_expired)
   );

   // Next state and next registered output values; a done pulse beats expiry
   always_comb begin
      state_n   = state;
      timeout_c = 1'b0;
      case (state)
         IDLE:      if (job_valid) state_n = PRE_GO;
         PRE_GO:    state_n = PRE_WAIT;
         PRE_WAIT: begin
            if (imdct_done)      state_n = FFT_GO;
            else if (wd_expired) begin state_n = IDLE; timeout_c = 1'b1; end
         end
         FFT_GO:    state_n = FFT_WAIT;
         FFT_WAIT: begin
            if (fft_done)        state_n = POST_GO;
            else if (wd_expired) begin state_n = IDLE; timeout_c = 1'b1; end
         end
         POST_GO:   state_n = POST_WAIT;
         POST_WAIT: begin
            if (imdct_done)      state_n = FIN;
            else if (wd_expired) begin state_n = IDLE; timeout_c = 1'b1; end
         end
         FIN:       state_n = IDLE;
         default:   state_n = IDLE;
      endcase

      accept_c = (state == IDLE) && job_valid;
      ready_n  = (state_n == IDLE);
      busy_n   = (state_n != IDLE);
      istart_n = (state_n == PRE_GO) || (state_n == POST_GO);
      fstart_n = (state_n == FFT_GO);
      ram_n    = ((state_n == FFT_GO) || (state_n == FFT_WAIT)) ? RAM_FFT : RAM_IMDCT;
      jdone_n  = (state_n == FIN);

      mode_n = imdct_mode;
      if (state_n == PRE_GO)       mode_n = MODE_PRE;
      else if (state_n == POST_GO) mode_n = MODE_POST;

      err_n = err;
      if (timeout_c)    err_n = 1'b1;
      else if (err_clr) err_n = 1'b0;
   end

   // State register and Moore outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         job_ready   <= 1'b1;
         busy        <= 1'b0;
         imdct_start <= 1'b0;
         fft_start   <= 1'b0;
         ram_sel     <= RAM_IMDCT;
         job_done    <= 1'b0;
         imdct_mode  <= MODE_PRE;
         err         <= 1'b0;
      end else begin
         state       <= state_n;
         job_ready   <= ready_n;
         busy        <= busy_n;
         imdct_start <= istart_n;
         fft_start   <= fstart_n;
         ram_sel     <= ram_n;
         job_done    <= jdone_n;
         imdct_mode  <= mode_n;
         err         <= err_n;
      end
   end

   // Job parameters held from accept until the next accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imdct_es     <= 5'd0;
         imdct_tabidx <= 1'b0;
      end else if (accept_c) begin
         imdct_es     <= job_es;
         imdct_tabidx <= job_tabidx;
      end
   end

endmodule

// File: tb/tb_imdct_seq.sv
// Directed bench for imdct_seq: instance 0 uses TO_W=12, instance 1 uses TO_W=4.
module tb_imdct_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       job_valid, job_tabidx, imdct_done, fft_done, err_clr;
   logic [4:0] job_es;

   logic       job_ready[2], imdct_start[2], imdct_mode[2], imdct_tabidx[2];
   logic       fft_start[2], ram_sel[2], busy[2], job_done[2], err[2];
   logic [4:0] imdct_es[2];

   int sel;
   int n_checks = 0;
   int n_errors = 0;
   int viol;

   // Status bits: ready busy istart mode fstart ram jdone err
   localparam logic [7:0] ST_RESET     = 8'b1000_0000;
   localparam logic [7:0] ST_PRE_GO    = 8'b0110_0000;
   localparam logic [7:0] ST_PRE_WAIT  = 8'b0100_0000;
   localparam logic [7:0] ST_FFT_GO    = 8'b0100_1100;
   localparam logic [7:0] ST_FFT_WAIT  = 8'b0100_0100;
   localparam logic [7:0] ST_POST_GO   = 8'b0111_0000;
   localparam logic [7:0] ST_POST_WAIT = 8'b0101_0000;
   localparam logic [7:0] ST_FIN       = 8'b0101_0010;
   localparam logic [7:0] ST_IDLE_DONE = 8'b1001_0000;
   localparam logic [7:0] ST_TIMEOUT   = 8'b1000_0001;

   always #5 clk = ~clk;

   imdct_seq #(.TO_W(12)) dut (
      .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready[0]),
      .job_tabidx(job_tabidx), .job_es(job_es), .imdct_start(imdct_start[0]),
      .imdct_mode(imdct_mode[0]), .imdct_tabidx(imdct_tabidx[0]), .imdct_es(imdct_es[0]),
      .imdct_done(imdct_done), .fft_start(fft_start[0]), .fft_done(fft_done),
      .ram_sel(ram_sel[0]), .busy(busy[0]), .job_done(job_done[0]), .err(err[0]),
      .err_clr(err_clr)
   );

   imdct_seq #(.TO_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready[1]),
      .job_tabidx(job_tabidx), .job_es(job_es), .imdct_start(imdct_start[1]),
      .imdct_mode(imdct_mode[1]), .imdct_tabidx(imdct_tabidx[1]), .imdct_es(imdct_es[1]),
      .imdct_done(imdct_done), .fft_start(fft_start[1]), .fft_done(fft_done),
      .ram_sel(ram_sel[1]), .busy(busy[1]), .job_done(job_done[1]), .err(err[1]),
      .err_clr(err_clr)
   );

   typedef struct {
      int es; int tab; int l1; int l2; int l3;
      int exp_es; int exp_tab;
   } vec_t;

   vec_t tbl[4];

   function automatic logic [7:0] stat();
      return {job_ready[sel], busy[sel], imdct_start[sel], imdct_mode[sel],
              fft_start[sel], ram_sel[sel], job_done[sel], err[sel]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // l wait cycles checked for stable outputs, then a done pulse on the l-th
   task automatic wait_phase(input int l, input logic [7:0] wst, input int es, input int tab,
                             input bit e, input bit is_fft);
      for (int i = 0; i < l; i++) begin
         @(negedge clk);
         if (stat() !== (wst | 8'(e)) || imdct_es[sel] !== 5'(es) || imdct_tabidx[sel] !== 1'(tab))
            viol++;
      end
      if (is_fft) fft_done = 1'b1;
      else        imdct_done = 1'b1;
      @(negedge clk);
      fft_done   = 1'b0;
      imdct_done = 1'b0;
   endtask

   task automatic accept(input int es, input int tab, input bit hold);
      int n = 0;
      while (job_ready[sel] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("job_ready_wait", 32'(job_ready[sel]), 1);
      job_valid  = 1'b1;
      job_es     = 5'(es);
      job_tabidx = 1'(tab);
      viol       = 0;
      @(negedge clk);
      if (!hold) job_valid = 1'b0;
   endtask

   task automatic rest_from_fftgo(input int es, input int tab, input int l2, input int l3,
                                  input bit e, input string tag);
      check({tag, "_fft_go"}, stat(), ST_FFT_GO | 8'(e));
      wait_phase(l2, ST_FFT_WAIT, es, tab, e, 1'b1);
      check({tag, "_post_go"}, stat(), ST_POST_GO | 8'(e));
      wait_phase(l3, ST_POST_WAIT, es, tab, e, 1'b0);
      check({tag, "_fin"}, stat(), ST_FIN | 8'(e));
      @(negedge clk);
      check({tag, "_idle"}, stat(), ST_IDLE_DONE | 8'(e));
      check({tag, "_wait_viol"}, viol, 0);
   endtask

   task automatic finish_from_pre(input int es, input int tab, input int l1, input int l2,
                                  input int l3, input bit e, input string tag);
      check({tag, "_pre_go"}, stat(), ST_PRE_GO | 8'(e));
      check({tag, "_es"}, 32'(imdct_es[sel]), es);
      check({tag, "_tab"}, 32'(imdct_tabidx[sel]), tab);
      wait_phase(l1, ST_PRE_WAIT, es, tab, e, 1'b0);
      rest_from_fftgo(es, tab, l2, l3, e, tag);
   endtask

   task automatic do_reset(input string tag);
      int save = sel;
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      for (int s = 0; s < 2; s++) begin
         sel = s;
         check({tag, "_stat"}, stat(), ST_RESET);
         check({tag, "_es"}, 32'(imdct_es[s]), 0);
         check({tag, "_tab"}, 32'(imdct_tabidx[s]), 0);
      end
      sel = save;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{es: 7,  tab: 1, l1: 20, l2: 30, l3: 20, exp_es: 7,  exp_tab: 1};
      tbl[1] = '{es: 0,  tab: 0, l1: 1,  l2: 1,  l3: 1,  exp_es: 0,  exp_tab: 0};
      tbl[2] = '{es: 31, tab: 1, l1: 5,  l2: 1,  l3: 9,  exp_es: 31, exp_tab: 1};
      tbl[3] = '{es: 18, tab: 0, l1: 3,  l2: 7,  l3: 2,  exp_es: 18, exp_tab: 0};

      sel = 0; viol = 0;
      rst_n = 1'b0; job_valid = 1'b0; job_tabidx = 1'b0; job_es = 5'd0;
      imdct_done = 1'b0; fft_done = 1'b0; err_clr = 1'b0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s;
         check("reset_stat", stat(), ST_RESET);
         check("reset_es", 32'(imdct_es[s]), 0);
      end
      sel = 0;
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven complete jobs on the wide-watchdog instance
      for (int i = 0; i < 4; i++) begin
         accept(tbl[i].es, tbl[i].tab, 1'b0);
         finish_from_pre(tbl[i].exp_es, tbl[i].exp_tab, tbl[i].l1, tbl[i].l2, tbl[i].l3,
                         1'b0, $sformatf("vec%0d", i));
      end

      // Back-to-back: job_valid held, es changes 3 -> 9 only at the second accept
      accept(3, 0, 1'b1);
      job_es = 5'd9;
      finish_from_pre(3, 0, 2, 3, 2, 1'b0, "b2b1");
      check("b2b_es_hold", 32'(imdct_es[0]), 3);
      @(negedge clk);
      job_valid = 1'b0;
      finish_from_pre(9, 0, 2, 2, 2, 1'b0, "b2b2");

      // Reset asserted during POST_WAIT, then a fresh job
      accept(11, 1, 1'b0);
      check("rst_pre_go", stat(), ST_PRE_GO);
      wait_phase(2, ST_PRE_WAIT, 11, 1, 1'b0, 1'b0);
      check("rst_fft_go", stat(), ST_FFT_GO);
      wait_phase(2, ST_FFT_WAIT, 11, 1, 1'b0, 1'b1);
      check("rst_post_go", stat(), ST_POST_GO);
      repeat (3) @(negedge clk);
      check("rst_post_wait", stat(), ST_POST_WAIT);
      do_reset("rst_mid");
      @(negedge clk);
      check("rst_ready", stat(), ST_RESET);
      accept(12, 1, 1'b0);
      finish_from_pre(12, 1, 4, 4, 4, 1'b0, "after_rst");

      // Stray done pulses in IDLE, in PRE_GO and fft_done in PRE_WAIT
      imdct_done = 1'b1; @(negedge clk); imdct_done = 1'b0;
      check("stray_idle_imdct", stat(), ST_IDLE_DONE);
      fft_done = 1'b1; @(negedge clk); fft_done = 1'b0;
      check("stray_idle_fft", stat(), ST_IDLE_DONE);
      accept(20, 0, 1'b0);
      check("stray_pre_go", stat(), ST_PRE_GO);
      imdct_done = 1'b1; @(negedge clk); imdct_done = 1'b0;
      check("stray_go_imdct", stat(), ST_PRE_WAIT);
      fft_done = 1'b1; @(negedge clk); fft_done = 1'b0;
      check("stray_wait_fft", stat(), ST_PRE_WAIT);
      wait_phase(3, ST_PRE_WAIT, 20, 0, 1'b0, 1'b0);
      rest_from_fftgo(20, 0, 2, 2, 1'b0, "stray");

      // Narrow-watchdog instance: timeout, err stickiness, set-over-clear, race
      do_reset("to_init");
      sel = 1;
      accept(4, 0, 1'b0);
      check("to_pre_go", stat(), ST_PRE_GO);
      wait_phase(3, ST_PRE_WAIT, 4, 0, 1'b0, 1'b0);
      check("to_fft_go", stat(), ST_FFT_GO);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (stat() !== ST_FFT_WAIT) viol++;
      end
      check("to_fft_wait_viol", viol, 0);
      @(negedge clk);
      check("to_idle", stat(), ST_TIMEOUT);
      @(negedge clk);
      check("to_no_done", stat(), ST_TIMEOUT);

      accept(6, 1, 1'b0);
      finish_from_pre(6, 1, 2, 2, 2, 1'b1, "err_job");
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      check("err_clr", stat(), ST_IDLE_DONE);

      accept(2, 0, 1'b0);
      err_clr = 1'b1;
      check("prio_pre_go", stat(), ST_PRE_GO);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (stat() !== ST_PRE_WAIT) viol++;
      end
      check("prio_wait_viol", viol, 0);
      @(negedge clk);
      check("prio_set_wins", stat(), ST_TIMEOUT);
      @(negedge clk);
      check("prio_clr_after", stat(), ST_RESET);
      err_clr = 1'b0;

      accept(5, 0, 1'b0);
      finish_from_pre(5, 0, 16, 16, 16, 1'b0, "race");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
